// File: rtl/matrix_link_pkg.sv
// Shared definitions for the matrix serial link: command codes, bit-level FSM states, frame sizing.
package matrix_link_pkg;

  typedef enum logic [2:0] {
    A_NOP       = 3'd0,
    A_WRITE     = 3'd1,
    A_SEND_CELL = 3'd2,
    A_SEND_ROW  = 3'd3,
    A_SEND_COL  = 3'd4,
    A_SEND_ALL  = 3'd5,
    A_CLEAR     = 3'd6,
    A_ABORT     = 3'd7
  } action_e;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} tx_state_e;

  function automatic int frame_len(int data_w, int parity_en);
    return data_w + parity_en + 2;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_serializer.sv
// One framed word onto the line: start, data LSB first, optional even parity, stop.
module frame_serializer import matrix_link_pkg::*; #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] word,
  output logic              tx,
  output logic              frame_done
);
  localparam int F  = frame_len(DATA_W, PARITY_EN);
  localparam int BW = idx_w(CLKS_PER_BIT);
  localparam int IW = idx_w(DATA_W);

  tx_state_e      state;
  logic [BW-1:0]  baud;
  logic [IW-1:0]  bit_idx;
  logic [F-1:0]   fr;
  logic [F-1:0]   frame_w;
  logic           bit_end;

  assign bit_end    = (baud == BW'(CLKS_PER_BIT - 1));
  // Combinational so the next frame can load on the same edge the stop bit ends.
  assign frame_done = (state == S_STOP) && bit_end;

  always_comb begin
    frame_w = '1;
    frame_w[0] = 1'b0;
    frame_w[DATA_W:1] = word;
    if (PARITY_EN != 0) frame_w[DATA_W+1] = ^word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      fr      <= '1;
    end else if (abort) begin
      state <= S_IDLE;
      tx    <= 1'b1;
      baud  <= '0;
    end else if (load) begin
      state   <= S_START;
      tx      <= frame_w[0];
      fr      <= frame_w;
      baud    <= '0;
      bit_idx <= '0;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        baud <= '0;
        fr   <= {1'b1, fr[F-1:1]};
        tx   <= fr[1];
        case (state)
          S_START: state <= S_DATA;
          S_DATA: begin
            if (bit_idx == IW'(DATA_W - 1)) state <= (PARITY_EN != 0) ? S_PAR : S_STOP;
            else bit_idx <= bit_idx + IW'(1);
          end
          S_PAR:   state <= S_STOP;
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end else begin
        baud <= baud + BW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_burst_tx.sv
// ROWS x COLS cell store with command decode and a burst cursor feeding the frame serializer.
module matrix_burst_tx import matrix_link_pkg::*; #(
  parameter  int ROWS         = 2,
  parameter  int COLS         = 4,
  parameter  int DATA_W       = 8,
  parameter  int CLKS_PER_BIT = 4,
  parameter  int PARITY_EN    = 1,
  localparam int RW           = idx_w(ROWS),
  localparam int CW           = idx_w(COLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  input  logic [RW-1:0]     row,
  input  logic [CW-1:0]     col,
  input  logic [2:0]        action,
  output logic              tx,
  output logic              t_busy,
  output logic [DATA_W-1:0] t_cell,
  output logic              done,
  output logic              cmd_drop
);
  localparam int NA = ROWS * COLS;
  localparam int NW = idx_w(NA);

  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] mem;
  action_e           act, kind;
  logic              row_ok, col_ok, is_send, send_ok, start, abort, more, frame_done, load;
  logic [RW-1:0]     cur_r, first_r, nxt_r;
  logic [CW-1:0]     cur_c, first_c, nxt_c;
  logic [NW-1:0]     cnt, n_last, first_last;
  logic [DATA_W-1:0] word;

  assign act    = action_e'(action);
  assign row_ok = int'(row) < ROWS;
  assign col_ok = int'(col) < COLS;
  assign t_cell = (row_ok && col_ok) ? mem[row][col] : '0;

  always_comb begin
    first_r    = row;
    first_c    = col;
    first_last = '0;
    send_ok    = 1'b0;
    is_send    = 1'b1;
    case (act)
      A_SEND_CELL: send_ok = row_ok && col_ok;
      A_SEND_ROW: begin
        first_c    = '0;
        first_last = NW'(COLS - 1);
        send_ok    = row_ok;
      end
      A_SEND_COL: begin
        first_r    = '0;
        first_last = NW'(ROWS - 1);
        send_ok    = col_ok;
      end
      A_SEND_ALL: begin
        first_r    = '0;
        first_c    = '0;
        first_last = NW'(NA - 1);
        send_ok    = 1'b1;
      end
      default: is_send = 1'b0;
    endcase
  end

  // Cursor of the frame that follows the one currently on the line.
  always_comb begin
    nxt_r = cur_r;
    nxt_c = cur_c;
    case (kind)
      A_SEND_ROW: nxt_c = cur_c + CW'(1);
      A_SEND_COL: nxt_r = cur_r + RW'(1);
      A_SEND_ALL: begin
        if (int'(cur_c) == COLS - 1) begin
          nxt_c = '0;
          nxt_r = cur_r + RW'(1);
        end else begin
          nxt_c = cur_c + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign abort = (act == A_ABORT) && t_busy;
  assign start = is_send && send_ok && !t_busy;
  assign more  = (cnt != n_last);
  assign load  = start || (t_busy && frame_done && more && !abort);
  assign word  = start ? mem[first_r][first_c] : mem[nxt_r][nxt_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (act == A_CLEAR) mem <= '0;
    else if (act == A_WRITE && row_ok && col_ok) mem[row][col] <= d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_busy   <= 1'b0;
      done     <= 1'b0;
      cmd_drop <= 1'b0;
      kind     <= A_NOP;
      cur_r    <= '0;
      cur_c    <= '0;
      cnt      <= '0;
      n_last   <= '0;
    end else begin
      done     <= 1'b0;
      cmd_drop <= is_send && (t_busy || !send_ok);
      if (abort) begin
        t_busy <= 1'b0;
      end else if (start) begin
        t_busy <= 1'b1;
        kind   <= act;
        cur_r  <= first_r;
        cur_c  <= first_c;
        cnt    <= '0;
        n_last <= first_last;
      end else if (t_busy && frame_done) begin
        if (more) begin
          cur_r <= nxt_r;
          cur_c <= nxt_c;
          cnt   <= cnt + NW'(1);
        end else begin
          t_busy <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  frame_serializer #(
    .DATA_W(DATA_W), .CLKS_PER_BIT(CLKS_PER_BIT), .PARITY_EN(PARITY_EN)
  ) u_ser (
    .clk(clk), .rst_n(rst_n), .load(load), .abort(abort),
    .word(word), .tx(tx), .frame_done(frame_done)
  );

endmodule

// File: tb/tb_matrix_burst_tx.sv
// Bench for matrix_burst_tx: cell table, reference-model bursts, abort/reset and range corners.
module tb_matrix_burst_tx;
  import matrix_link_pkg::*;

  localparam int ROWS = 2, COLS = 4, DW = 8, CPB = 4, PE = 1;
  localparam int FC   = frame_len(DW, PE) * CPB;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] d = '0;
  logic          row = 1'b0;
  logic [1:0]    col = '0, col3 = '0;
  logic [2:0]    action = '0, action3 = '0;
  wire           tx, t_busy, done, cmd_drop, tx3, busy3, done3, drop3;
  wire [DW-1:0]  t_cell, cell3;

  matrix_burst_tx #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(PE)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .row(row), .col(col), .action(action),
    .tx(tx), .t_busy(t_busy), .t_cell(t_cell), .done(done), .cmd_drop(cmd_drop));

  matrix_burst_tx #(.ROWS(2), .COLS(3), .DATA_W(DW), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d), .row(row), .col(col3), .action(action3),
    .tx(tx3), .t_busy(busy3), .t_cell(cell3), .done(done3), .cmd_drop(drop3));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] model [ROWS][COLS];

  typedef struct { int r; int c; } cell_t;
  typedef struct { logic [2:0] act; int r; int c; logic [DW-1:0] dv; logic [DW-1:0] exp_cell; } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [DW-1:0] v, input int b);
    if (b == 0) return 1'b0;
    if (b <= DW) return v[b-1];
    if (PE != 0 && b == DW + 1) return ^v;
    return 1'b1;
  endfunction

  // One burst with at most one side command driven in cycle side_t (0 = none).
  task automatic burst(input logic [2:0] act, input int r, input int c, input int side_t,
                       input logic [2:0] side_act, input int sr, input int sc, input logic [DW-1:0] sd);
    cell_t cells[$];
    int total, bad_tx = 0, bad_busy = 0, bad_drop = 0;
    logic [DW-1:0] fv = '0;
    logic pend_w = 0, pend_c = 0, aborted = 0, side_send, exp_drop;
    int pr = 0, pc = 0;
    logic [DW-1:0] pd = '0;
    case (act)
      A_SEND_CELL: cells.push_back('{r, c});
      A_SEND_ROW:  for (int j = 0; j < COLS; j++) cells.push_back('{r, j});
      A_SEND_COL:  for (int i = 0; i < ROWS; i++) cells.push_back('{i, c});
      default:     for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) cells.push_back('{i, j});
    endcase
    total = cells.size() * FC;
    side_send = side_t != 0 && side_act >= A_SEND_CELL && side_act <= A_SEND_ALL;
    @(negedge clk);
    action = act; row = 1'(r); col = 2'(c);
    for (int t = 1; t <= total; t++) begin
      @(negedge clk);
      if ((t - 1) % FC == 0) fv = model[cells[(t-1)/FC].r][cells[(t-1)/FC].c];
      if (pend_w) model[pr][pc] = pd;
      if (pend_c) model = '{default: '0};
      pend_w = 0; pend_c = 0;
      if (tx !== frame_bit(fv, ((t - 1) % FC) / CPB)) bad_tx++;
      if (t_busy !== 1'b1 || done !== 1'b0) bad_busy++;
      exp_drop = side_send && (t == side_t + 1);
      if (cmd_drop !== exp_drop) bad_drop++;
      action = A_NOP;
      if (t == side_t) begin
        action = side_act; row = 1'(sr); col = 2'(sc); d = sd;
        if (side_act == A_WRITE) begin pend_w = 1; pr = sr; pc = sc; pd = sd; end
        if (side_act == A_CLEAR) pend_c = 1;
        if (side_act == A_ABORT) begin aborted = 1; break; end
      end
    end
    @(negedge clk);
    action = A_NOP;
    if (pend_w) model[pr][pc] = pd;
    if (pend_c) model = '{default: '0};
    chk("tx_stream", bad_tx, 0);
    chk("busy_high", bad_busy, 0);
    chk("drop_pulse", bad_drop, 0);
    chk("busy_fall", t_busy, 0);
    chk("tx_idle", tx, 1);
    chk(aborted ? "abort_no_done" : "done_pulse", done, aborted ? 0 : 1);
    @(negedge clk);
    chk("done_len", done, 0);
  endtask

  initial begin
    vec_t vt[$];
    model = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", t_busy, 0);
    chk("rst_done", done, 0);
    chk("rst_drop", cmd_drop, 0);
    chk("rst_cell", t_cell, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) vt.push_back('{A_WRITE, i / 4, i % 4, 8'(17 * (i + 1)), 8'(17 * (i + 1))});
    vt.push_back('{A_NOP, 1, 3, 8'h00, 8'h88});
    vt.push_back('{A_NOP, 0, 0, 8'h00, 8'h11});
    vt.push_back('{A_NOP, 0, 2, 8'h00, 8'h33});
    foreach (vt[i]) begin
      @(negedge clk);
      action = vt[i].act; row = 1'(vt[i].r); col = 2'(vt[i].c); d = vt[i].dv;
      if (vt[i].act == A_WRITE) model[vt[i].r][vt[i].c] = vt[i].dv;
      @(negedge clk);
      action = A_NOP;
      chk("table_cell", t_cell, vt[i].exp_cell);
    end

    burst(A_SEND_CELL, 0, 1, 0, A_NOP, 0, 0, 0);
    burst(A_SEND_ROW, 0, 0, 0, A_NOP, 0, 0, 0);
    burst(A_SEND_COL, 0, 2, 0, A_NOP, 0, 0, 0);
    burst(A_SEND_ALL, 0, 0, 0, A_NOP, 0, 0, 0);
    burst(A_SEND_ALL, 0, 0, 10, A_SEND_ROW, 1, 0, 0);
    burst(A_SEND_ALL, 0, 0, 50, A_WRITE, 1, 3, 8'hAB);
    chk("wr_mid_burst", model[1][3], 8'hAB);
    burst(A_SEND_ROW, 0, 0, 20, A_ABORT, 0, 0, 0);
    burst(A_SEND_CELL, 1, 2, 0, A_NOP, 0, 0, 0);
    burst(A_SEND_ROW, 1, 0, 60, A_CLEAR, 0, 0, 0);

    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) begin
        @(negedge clk);
        action = A_WRITE; row = 1'(i); col = 2'(j); d = 8'($urandom);
        model[i][j] = d;
      end
    for (int k = 0; k < 6; k++) begin
      logic [2:0] ka, sa;
      int n, st;
      ka = 3'($urandom_range(A_SEND_CELL, A_SEND_ALL));
      n  = (ka == A_SEND_CELL) ? 1 : (ka == A_SEND_ROW) ? COLS : (ka == A_SEND_COL) ? ROWS : ROWS * COLS;
      sa = ($urandom_range(0, 1) == 0) ? A_WRITE : 3'($urandom_range(A_SEND_CELL, A_SEND_ALL));
      st = $urandom_range(1, n * FC - 1);
      burst(ka, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), st, sa,
            $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), 8'($urandom));
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    action = A_SEND_ALL;
    @(negedge clk);
    action = A_NOP; row = 1'b1; col = 2'd3;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", t_busy, 0);
    chk("arst_cell", t_cell, 0);
    model = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done, 0);
    chk("arst_idle", t_busy, 0);

    // Non-power-of-two column count: out-of-range column handling.
    @(negedge clk);
    action3 = A_SEND_CELL; row = 1'b0; col3 = 2'd3;
    @(negedge clk);
    action3 = A_NOP;
    chk("oor_drop", drop3, 1);
    chk("oor_busy", busy3, 0);
    chk("oor_tx", tx3, 1);
    action3 = A_WRITE; d = 8'h5A;
    @(negedge clk);
    action3 = A_NOP;
    chk("oor_cell", cell3, 0);
    action3 = A_WRITE; col3 = 2'd2;
    @(negedge clk);
    action3 = A_NOP;
    chk("inr_cell", cell3, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
